fpu_scoreboard: RTL and testbench

Issue-side scheduler for the multi-cycle floating-point unit.
- Tracks pending FP destination registers and reserves the single FP register-file writeback port.
- Sequences the non-pipelined divide/sqrt unit.
- Produces `stall_fpu` for the pipeline hazard unit, plus the writeback strobe and register index that commit FPU results.
- Sits beside the ID stage; its stall merges with load-use stalls in the hazard unit.

---
 rtl/fpu_pkg.sv | 43 ++++
 rtl/fpu_scoreboard_if.sv | 44 ++++
 rtl/fpu_wb_reserve.sv | 62 ++++++
 rtl/fpu_scoreboard.sv | 121 ++++++++++++
 tb/tb_fpu_scoreboard.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU scheduling types: op classes, writeback slot layout, default latencies
// and the latency lookup used by the issue-side scoreboard.
package fpu_pkg;

  typedef enum logic [1:0] {
    FCLS_ADD = 2'd0,
    FCLS_MUL = 2'd1,
    FCLS_DIV = 2'd2,
    FCLS_SGL = 2'd3
  } fp_class_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } wb_slot_t;

  localparam int LAT_ADD_DEF = 3;
  localparam int LAT_MUL_DEF = 4;
  localparam int LAT_DIV_DEF = 12;
  localparam int LAT_SGL     = 1;

  function automatic int lat_of(input fp_class_t cls, input int lat_add,
                                input int lat_mul, input int lat_div);
    int lat;
    case (cls)
      FCLS_ADD: lat = lat_add;
      FCLS_MUL: lat = lat_mul;
      FCLS_DIV: lat = lat_div;
      FCLS_SGL: lat = LAT_SGL;
      default:  lat = LAT_SGL;
    endcase
    return lat;
  endfunction

  function automatic int lat_max(input int lat_add, input int lat_mul, input int lat_div);
    int m;
    m = (lat_add > lat_mul) ? lat_add : lat_mul;
    m = (m > lat_div) ? m : lat_div;
    m = (m > LAT_SGL) ? m : LAT_SGL;
    return m;
  endfunction

endpackage

// File: rtl/fpu_scoreboard_if.sv
// ID-stage issue bundle and scheduler responses of the FPU scoreboard.
// Optional perf counters appear only when FPU_SCB_PERF_EN is defined.
interface fpu_scoreboard_if;
  import fpu_pkg::*;

  logic        issue_valid_id;
  fp_class_t   issue_class_id;
  logic [2:0]  frs_use_id;
  logic [4:0]  frs1_id;
  logic [4:0]  frs2_id;
  logic [4:0]  frs3_id;
  logic [4:0]  frd_id;
  logic        frd_we_id;
  logic        pipe_stall_id;
  logic        flush_ex;
  logic        stall_fpu;
  logic        wb_valid;
  logic [4:0]  wb_frd;
  logic [31:0] busy_vec;
  logic        div_busy;
`ifdef FPU_SCB_PERF_EN
  logic [31:0] raw_stall_cnt;
  logic [31:0] struct_stall_cnt;
`endif

  modport master (
    output issue_valid_id, issue_class_id, frs_use_id, frs1_id, frs2_id, frs3_id,
    output frd_id, frd_we_id, pipe_stall_id, flush_ex,
    input  stall_fpu, wb_valid, wb_frd, busy_vec, div_busy
`ifdef FPU_SCB_PERF_EN
    , input raw_stall_cnt, struct_stall_cnt
`endif
  );

  modport slave (
    input  issue_valid_id, issue_class_id, frs_use_id, frs1_id, frs2_id, frs3_id,
    input  frd_id, frd_we_id, pipe_stall_id, flush_ex,
    output stall_fpu, wb_valid, wb_frd, busy_vec, div_busy
`ifdef FPU_SCB_PERF_EN
    , output raw_stall_cnt, struct_stall_cnt
`endif
  );

endinterface

// File: rtl/fpu_wb_reserve.sv
// Writeback-port reservation: a shift register of {valid, rd} slots whose
// bottom entry is the writeback strobe, plus the slot-occupied conflict check.
module fpu_wb_reserve
  import fpu_pkg::*;
#(
  parameter int LAT_MAX = 12,
  parameter int LW      = $clog2(LAT_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [LW-1:0] lat,
  input  logic          res_we,
  input  logic [4:0]    res_rd,
  output logic          conflict,
  output logic          wb_valid,
  output logic [4:0]    wb_frd
);

  wb_slot_t slot_r     [LAT_MAX];
  wb_slot_t shift_s    [LAT_MAX];
  wb_slot_t slot_nxt_s [LAT_MAX];

  // A new op would land in slot[lat-1] next cycle, which is where slot[lat] shifts to.
  always_comb begin
    conflict = 1'b0;
    for (int k = 0; k < LAT_MAX; k++) begin
      conflict = conflict | ((LW'(k) == lat) & slot_r[k].valid);
    end
  end

  // Downward shift with the top entry emptied.
  always_comb begin
    for (int k = 0; k < LAT_MAX - 1; k++) begin
      shift_s[k] = slot_r[k + 1];
    end
    shift_s[LAT_MAX - 1] = '0;
  end

  // New reservation overrides whatever shifts into its position.
  always_comb begin
    for (int k = 0; k < LAT_MAX; k++) begin
      slot_nxt_s[k] = (res_we && (LW'(k + 1) == lat)) ? {1'b1, res_rd} : shift_s[k];
    end
  end

  // Slot state; reset drops every reservation, including results still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT_MAX; k++) begin
        slot_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < LAT_MAX; k++) begin
        slot_r[k] <= slot_nxt_s[k];
      end
    end
  end

  assign wb_valid = slot_r[0].valid;
  assign wb_frd   = slot_r[0].rd;

endmodule

// File: rtl/fpu_scoreboard.sv
// Issue-side FPU scheduler: pending-write tracking, writeback-port reservation,
// divider sequencing and stall_fpu. Define FPU_SCB_PERF_EN for stall counters.
module fpu_scoreboard
  import fpu_pkg::*;
#(
  parameter int LAT_ADD = LAT_ADD_DEF,
  parameter int LAT_MUL = LAT_MUL_DEF,
  parameter int LAT_DIV = LAT_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  fpu_scoreboard_if.slave  bus
);

  localparam int LAT_MAX = lat_max(LAT_ADD, LAT_MUL, LAT_DIV);
  localparam int LW      = $clog2(LAT_MAX + 1);
  localparam int DW      = $clog2(LAT_DIV + 1);

  logic [31:0]   busy_r;
  logic [31:0]   busy_set_s;
  logic [31:0]   busy_clr_s;
  logic [DW-1:0] div_cnt_r;
  logic          div_busy_s;
  logic [LW-1:0] lat_s;
  logic          is_div_s;
  logic          raw_s;
  logic          waw_s;
  logic          wbc_s;
  logic          divc_s;
  logic          slot_conflict_s;
  logic          stall_s;
  logic          fire_s;
  logic          res_we_s;
  logic          wb_valid_s;
  logic [4:0]    wb_frd_s;

  assign lat_s      = LW'(lat_of(bus.issue_class_id, LAT_ADD, LAT_MUL, LAT_DIV));
  assign is_div_s   = (bus.issue_class_id == FCLS_DIV);
  assign div_busy_s = (div_cnt_r != '0);

  // Hazard terms look only at registered state and ID inputs, never at the
  // external stall or flush, so merging stalls in the hazard unit cannot loop.
  always_comb begin
    raw_s   = (bus.frs_use_id[0] & busy_r[bus.frs1_id])
            | (bus.frs_use_id[1] & busy_r[bus.frs2_id])
            | (bus.frs_use_id[2] & busy_r[bus.frs3_id]);
    waw_s   = bus.frd_we_id & busy_r[bus.frd_id];
    wbc_s   = bus.frd_we_id & slot_conflict_s;
    divc_s  = is_div_s & div_busy_s;
    stall_s = bus.issue_valid_id & (raw_s | waw_s | wbc_s | divc_s);
    fire_s  = bus.issue_valid_id & ~stall_s & ~bus.pipe_stall_id & ~bus.flush_ex;
  end

  assign res_we_s = fire_s & bus.frd_we_id;

  fpu_wb_reserve #(
    .LAT_MAX (LAT_MAX),
    .LW      (LW)
  ) u_wb_reserve (
    .clk      (clk),
    .rst      (rst),
    .lat      (lat_s),
    .res_we   (res_we_s),
    .res_rd   (bus.frd_id),
    .conflict (slot_conflict_s),
    .wb_valid (wb_valid_s),
    .wb_frd   (wb_frd_s)
  );

  assign busy_set_s = res_we_s   ? (32'd1 << bus.frd_id) : 32'd0;
  assign busy_clr_s = wb_valid_s ? (32'd1 << wb_frd_s)   : 32'd0;

  // Pending-write bits: set at reservation, cleared in the writeback cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 32'd0;
    end else begin
      busy_r <= (busy_r & ~busy_clr_s) | busy_set_s;
    end
  end

  // Divider occupancy countdown; a DIV with no FP destination still occupies it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_r <= '0;
    end else if (fire_s && is_div_s) begin
      div_cnt_r <= DW'(LAT_DIV);
    end else if (div_busy_s) begin
      div_cnt_r <= div_cnt_r - DW'(1);
    end else begin
      div_cnt_r <= div_cnt_r;
    end
  end

`ifdef FPU_SCB_PERF_EN
  logic [31:0] raw_cnt_r;
  logic [31:0] struct_cnt_r;

  // Stall-cause counters; dependency stalls take precedence over structural ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_cnt_r    <= 32'd0;
      struct_cnt_r <= 32'd0;
    end else begin
      raw_cnt_r    <= raw_cnt_r + {31'd0, bus.issue_valid_id & (raw_s | waw_s)};
      struct_cnt_r <= struct_cnt_r
                    + {31'd0, bus.issue_valid_id & (wbc_s | divc_s) & ~(raw_s | waw_s)};
    end
  end

  assign bus.raw_stall_cnt    = raw_cnt_r;
  assign bus.struct_stall_cnt = struct_cnt_r;
`endif

  assign bus.stall_fpu = stall_s;
  assign bus.wb_valid  = wb_valid_s;
  assign bus.wb_frd    = wb_frd_s;
  assign bus.busy_vec  = busy_r;
  assign bus.div_busy  = div_busy_s;

endmodule

// File: tb/tb_fpu_scoreboard.sv
// Directed bench for fpu_scoreboard: expected writebacks are queued at issue
// time and a negedge monitor pops and compares them against the DUT strobe.
module tb_fpu_scoreboard;
  import fpu_pkg::*;

  typedef struct {
    int         cyc;
    logic [4:0] frd;
  } wb_exp_t;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  int      cyc = 0;
  int      n_cmp = 0;
  int      n_err = 0;
  wb_exp_t wb_q[$];

  fpu_scoreboard_if bus();

  fpu_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid_id = 1'b0;
    bus.issue_class_id = FCLS_ADD;
    bus.frs_use_id     = 3'b000;
    bus.frs1_id        = 5'd0;
    bus.frs2_id        = 5'd0;
    bus.frs3_id        = 5'd0;
    bus.frd_id         = 5'd0;
    bus.frd_we_id      = 1'b0;
    bus.pipe_stall_id  = 1'b0;
    bus.flush_ex       = 1'b0;
  endtask

  task automatic issue(input fp_class_t cls, input logic [4:0] frd, input logic we,
                       input logic [2:0] use_f, input logic [4:0] s1);
    idle();
    bus.issue_valid_id = 1'b1;
    bus.issue_class_id = cls;
    bus.frd_id         = frd;
    bus.frd_we_id      = we;
    bus.frs_use_id     = use_f;
    bus.frs1_id        = s1;
    bus.frs2_id        = s1;
    bus.frs3_id        = s1;
  endtask

  task automatic expect_wb(input int at, input logic [4:0] frd);
    wb_q.push_back('{cyc: at, frd: frd});
  endtask

  task automatic idle_cycles(input int n);
    idle();
    for (int i = 0; i < n; i++) next();
  endtask

  // Writeback monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    wb_exp_t e;
    if (bus.wb_valid === 1'b1) begin
      if (wb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL wb_unexpected: got wb_frd %0d expected no writeback (cycle %0d)",
                 bus.wb_frd, cyc);
      end else begin
        e = wb_q.pop_front();
        chk("wb_frd", {27'd0, bus.wb_frd}, {27'd0, e.frd});
        chk("wb_cycle", cyc, e.cyc);
      end
    end else if (wb_q.size() != 0 && wb_q[0].cyc <= cyc) begin
      e = wb_q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL wb_missing: got no writeback expected f%0d at cycle %0d", e.frd, e.cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    idle();
    // Reset state; stall stays low even with a DIV presented in ID.
    next();
    issue(FCLS_DIV, 5'd1, 1'b1, 3'b111, 5'd1);
    half();
    chk("rst_stall", {31'd0, bus.stall_fpu}, 32'd0);
    chk("rst_busy", bus.busy_vec, 32'd0);
    chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("rst_div_busy", {31'd0, bus.div_busy}, 32'd0);
    next();
    rst = 1'b0;
    idle_cycles(2);

    // RAW on an ADD result.
    issue(FCLS_ADD, 5'd3, 1'b1, 3'b000, 5'd0);
    half();
    chk("add_fire_stall", {31'd0, bus.stall_fpu}, 32'd0);
    expect_wb(cyc + 3, 5'd3);
    next();
    issue(FCLS_ADD, 5'd4, 1'b1, 3'b001, 5'd3);
    for (int i = 0; i < 3; i++) begin
      half();
      chk("raw_stall", {31'd0, bus.stall_fpu}, 32'd1);
      chk("raw_busy", bus.busy_vec, 32'h0000_0008);
      next();
    end
    half();
    chk("raw_release", {31'd0, bus.stall_fpu}, 32'd0);
    expect_wb(cyc + 3, 5'd4);
    next();
    idle_cycles(5);
    half();
    chk("raw_drain_busy", bus.busy_vec, 32'd0);
`ifdef FPU_SCB_PERF_EN
    chk("perf_raw_cnt", bus.raw_stall_cnt, 32'd3);
    chk("perf_struct_cnt", bus.struct_stall_cnt, 32'd0);
`endif
    next();

    // Writeback-port conflict: MUL f1 then ADD f2.
    issue(FCLS_MUL, 5'd1, 1'b1, 3'b000, 5'd0);
    half();
    chk("mul_fire_stall", {31'd0, bus.stall_fpu}, 32'd0);
    expect_wb(cyc + 4, 5'd1);
    next();
    issue(FCLS_ADD, 5'd2, 1'b1, 3'b000, 5'd0);
    half();
    chk("wbc_stall", {31'd0, bus.stall_fpu}, 32'd1);
    chk("wbc_busy", bus.busy_vec, 32'h0000_0002);
    next();
    half();
    chk("wbc_release", {31'd0, bus.stall_fpu}, 32'd0);
    expect_wb(cyc + 3, 5'd2);
    next();
    idle_cycles(6);

    // WAW on f0, which is an ordinary register.
    issue(FCLS_ADD, 5'd0, 1'b1, 3'b000, 5'd0);
    half();
    expect_wb(cyc + 3, 5'd0);
    next();
    issue(FCLS_MUL, 5'd0, 1'b1, 3'b000, 5'd0);
    for (int i = 0; i < 3; i++) begin
      half();
      chk("waw_stall", {31'd0, bus.stall_fpu}, 32'd1);
      chk("waw_busy", bus.busy_vec, 32'h0000_0001);
      next();
    end
    half();
    chk("waw_release", {31'd0, bus.stall_fpu}, 32'd0);
    expect_wb(cyc + 4, 5'd0);
    next();
    idle_cycles(6);

    // Divider structural hazard.
    issue(FCLS_DIV, 5'd5, 1'b1, 3'b000, 5'd0);
    half();
    chk("div_fire_stall", {31'd0, bus.stall_fpu}, 32'd0);
    expect_wb(cyc + 12, 5'd5);
    next();
    issue(FCLS_DIV, 5'd6, 1'b1, 3'b000, 5'd0);
    for (int i = 0; i < 12; i++) begin
      half();
      chk("divc_stall", {31'd0, bus.stall_fpu}, 32'd1);
      chk("divc_busy", {31'd0, bus.div_busy}, 32'd1);
      next();
    end
    half();
    chk("div2_release", {31'd0, bus.stall_fpu}, 32'd0);
    chk("div_idle", {31'd0, bus.div_busy}, 32'd0);
    expect_wb(cyc + 12, 5'd6);
    next();
    idle_cycles(12);
    half();
    chk("div_done", {31'd0, bus.div_busy}, 32'd0);
    next();

    // Flush and external stall gate the fire.
    issue(FCLS_ADD, 5'd9, 1'b1, 3'b000, 5'd0);
    bus.flush_ex = 1'b1;
    half();
    chk("flush_stall_indep", {31'd0, bus.stall_fpu}, 32'd0);
    next();
    bus.flush_ex      = 1'b0;
    bus.pipe_stall_id = 1'b1;
    half();
    chk("flush_no_busy", bus.busy_vec, 32'd0);
    next();
    idle();
    half();
    chk("pstall_no_busy", bus.busy_vec, 32'd0);
    next();
    idle_cycles(4);

    // No FP destination: ADD reserves nothing; DIV still occupies the divider.
    issue(FCLS_ADD, 5'd10, 1'b0, 3'b000, 5'd0);
    next();
    issue(FCLS_DIV, 5'd11, 1'b0, 3'b000, 5'd0);
    half();
    chk("nodest_busy", bus.busy_vec, 32'd0);
    next();
    idle();
    half();
    chk("nodest_div_busy", {31'd0, bus.div_busy}, 32'd1);
    chk("nodest_busy2", bus.busy_vec, 32'd0);
    next();
    idle_cycles(13);

    // Reset mid-operation drops MUL f7 immediately.
    issue(FCLS_MUL, 5'd7, 1'b1, 3'b000, 5'd0);
    next();
    idle();
    half();
    chk("pre_rst_busy", bus.busy_vec, 32'h0000_0080);
    next();
    rst = 1'b1;
    #1;
    chk("async_rst_busy", bus.busy_vec, 32'd0);
    chk("async_rst_wb", {31'd0, bus.wb_valid}, 32'd0);
    next();
    rst = 1'b0;
    idle_cycles(6);
    half();
    chk("post_rst_busy", bus.busy_vec, 32'd0);

    t = wb_q.size();
    chk("sb_drained", t, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
